pc_ctrl: RTL



---
 rtl/pc_ctrl_pkg.sv | 21 ++
 rtl/pc_ctrl_src_encode.sv | 28 ++
 rtl/pc_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC update sequencer: FSM state encodings, PC mux
// selector codes and the decoded-source record passed from the priority encoder.
package pc_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UPDATE  = 3'd1;
  localparam logic [2:0] ST_EXC_EPC = 3'd2;
  localparam logic [2:0] ST_EXC_VEC = 3'd3;
  localparam logic [2:0] ST_HALT    = 3'd4;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEL_EXC    = 2'b11;

  typedef struct packed {
    logic [1:0] sel;
    logic       exc;
  } pc_src_t;

endpackage

// File: rtl/pc_ctrl_src_encode.sv
// Priority encoder for the PC source: exception > jump > taken branch > sequential.
module pc_ctrl_src_encode
  import pc_ctrl_pkg::*;
(
  input  logic    i_is_branch,
  input  logic    i_branch_taken,
  input  logic    i_is_jump,
  input  logic    i_exc_req,
  output pc_src_t o_src
);

  // Resolve request flags into a mux selector; a not-taken branch is sequential.
  always_comb begin
    o_src.sel = PC_SEL_SEQ;
    o_src.exc = 1'b0;
    if (i_exc_req) begin
      o_src.sel = PC_SEL_EXC;
      o_src.exc = 1'b1;
    end else if (i_is_jump) begin
      o_src.sel = PC_SEL_JUMP;
    end else if (i_is_branch && i_branch_taken) begin
      o_src.sel = PC_SEL_BRANCH;
    end else begin
      o_src.sel = PC_SEL_SEQ;
    end
  end

endmodule

// File: rtl/pc_ctrl.sv
// PC update sequencer: turns branch/jump/exception requests into a timed
// PC/EPC write sequence with ready/done handshake, hold stalls and double-fault halt.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int EXC_NEST_ALLOWED = 0
)
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pc_req,
  input  logic       i_is_branch,
  input  logic       i_branch_taken,
  input  logic       i_is_jump,
  input  logic       i_exc_req,
  input  logic [1:0] i_exc_code,
  input  logic       i_exc_ret,
  input  logic       i_hold,
  output logic       o_ready,
  output logic [1:0] o_pc_sel,
  output logic       o_pc_write,
  output logic       o_epc_write,
  output logic [1:0] o_cause_out,
  output logic       o_done,
  output logic       o_halted
);

  localparam logic NEST_OK = (EXC_NEST_ALLOWED != 0);

  logic [2:0] r_state;
  logic [1:0] r_pc_sel;
  logic [1:0] r_cause;
  logic       r_in_exc;
  logic       r_ret_pend;
  pc_src_t    w_src;
  logic       w_write_phase;

  pc_ctrl_src_encode u_src_encode (
    .i_is_branch    (i_is_branch),
    .i_branch_taken (i_branch_taken),
    .i_is_jump      (i_is_jump),
    .i_exc_req      (i_exc_req),
    .o_src          (w_src)
  );

  // Sequencer state, latched source/cause and in-exception bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_pc_sel   <= PC_SEL_SEQ;
      r_cause    <= 2'b00;
      r_in_exc   <= 1'b0;
      r_ret_pend <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_pc_req) begin
            if (w_src.exc) begin
              r_ret_pend <= 1'b0;
              if (r_in_exc && !NEST_OK) begin
                r_state <= ST_HALT;
              end else begin
                r_state  <= ST_EXC_EPC;
                r_pc_sel <= w_src.sel;
                r_cause  <= i_exc_code;
              end
            end else begin
              r_state    <= ST_UPDATE;
              r_pc_sel   <= w_src.sel;
              r_ret_pend <= i_exc_ret;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_UPDATE: begin
          if (!i_hold) begin
            r_state    <= ST_IDLE;
            r_ret_pend <= 1'b0;
            if (r_ret_pend) begin
              r_in_exc <= 1'b0;
            end
          end else begin
            r_state <= ST_UPDATE;
          end
        end
        // EPC capture is never stalled by hold.
        ST_EXC_EPC: begin
          r_in_exc <= 1'b1;
          r_state  <= ST_EXC_VEC;
        end
        ST_EXC_VEC: begin
          if (!i_hold) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_EXC_VEC;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign w_write_phase = (r_state == ST_UPDATE) || (r_state == ST_EXC_VEC);

  assign o_ready     = (r_state == ST_IDLE);
  assign o_pc_sel    = r_pc_sel;
  assign o_pc_write  = w_write_phase && !i_hold;
  assign o_done      = w_write_phase && !i_hold;
  assign o_epc_write = (r_state == ST_EXC_EPC);
  assign o_cause_out = r_cause;
  assign o_halted    = (r_state == ST_HALT);

endmodule
